// File: rtl/ram_filler.sv
// RAM fill engine: writes an address range with identity, constant or stepped data.
// Optional abort input enabled by defining RAM_FILLER_ABORT_EN.
module ram_filler #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH-1:0] end_addr,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic [DATA_WIDTH-1:0] step,
    input  logic                  grant,
`ifdef RAM_FILLER_ABORT_EN
    input  logic                  abort,
`endif
    output logic                  write_enable,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] ram_in,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                r_state;
    logic                  r_start_prev;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_end;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_step;
    logic [1:0]            r_mode;

    logic                  w_abort;
    logic                  w_start_edge;
    logic                  w_last;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic [DATA_WIDTH-1:0] w_next_data;
    logic [DATA_WIDTH-1:0] w_first_data;

    // Zero-extend or truncate an address to the data width.
    function automatic logic [DATA_WIDTH-1:0] f_fit(input logic [ADDR_WIDTH-1:0] a);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < DATA_WIDTH && i < ADDR_WIDTH; i++) begin
            r[i] = a[i];
        end
        return r;
    endfunction

`ifdef RAM_FILLER_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_start_edge = start && !r_start_prev;
    assign w_last       = (r_addr == r_end);
    assign w_next_addr  = r_addr + 1'b1;

    assign write_enable = (r_state == S_RUN) && grant && !w_abort;
    assign busy         = (r_state == S_RUN);
    assign done         = (r_state == S_DONE);
    assign address      = r_addr;
    assign ram_in       = r_data;

    always_comb begin
        w_next_data  = f_fit(w_next_addr);
        w_first_data = f_fit(start_addr);
        case (r_mode)
            2'b01:   w_next_data = r_data;
            2'b10:   w_next_data = r_data + r_step;
            default: w_next_data = f_fit(w_next_addr);
        endcase
        case (mode)
            2'b01, 2'b10: w_first_data = seed;
            default:      w_first_data = f_fit(start_addr);
        endcase
    end

    // Previous-start resets high so a start held through reset is not an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_start_prev <= 1'b1;
            r_addr       <= '0;
            r_end        <= '0;
            r_data       <= '0;
            r_step       <= '0;
            r_mode       <= '0;
        end else begin
            r_start_prev <= start;
            case (r_state)
                S_IDLE: begin
                    if (w_start_edge) begin
                        r_state <= S_RUN;
                        r_addr  <= start_addr;
                        r_end   <= end_addr;
                        r_mode  <= mode;
                        r_step  <= step;
                        r_data  <= w_first_data;
                    end
                end
                S_RUN: begin
                    if (w_abort) begin
                        r_state <= S_IDLE;
                    end else if (grant) begin
                        r_addr <= w_next_addr;
                        r_data <= w_next_data;
                        if (w_last) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_filler.sv
// Directed bench for ram_filler: table of fills plus reset and abort sequences.
// Expected writes come from hand-computed table entries and a small data model.
module tb_ram_filler;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] start_addr;
    logic [7:0] end_addr;
    logic [1:0] mode;
    logic [7:0] seed;
    logic [7:0] step;
    logic       grant;
    logic       abort;
    logic       write_enable;
    logic [7:0] address;
    logic [7:0] ram_in;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] sa;
        logic [7:0] ea;
        logic [1:0] md;
        logic [7:0] sd;
        logic [7:0] st;
        bit         tog;
        bit         retrig;
        int         cnt;
        logic [7:0] last_a;
        logic [7:0] last_d;
    } vec_t;

    vec_t vecs[5];

    ram_filler #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .start_addr(start_addr),
        .end_addr(end_addr),
        .mode(mode),
        .seed(seed),
        .step(step),
        .grant(grant),
`ifdef RAM_FILLER_ABORT_EN
        .abort(abort),
`endif
        .write_enable(write_enable),
        .address(address),
        .ram_in(ram_in),
        .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_data(input vec_t v, input int k, input logic [7:0] ea);
        case (v.md)
            2'b01:   return v.sd;
            2'b10:   return v.sd + 8'(k) * v.st;
            default: return ea;
        endcase
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_we"}, 32'(write_enable), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_addr"}, 32'(address), 0);
        chk({tag, "_data"}, 32'(ram_in), 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int k, cyc, nbusy;
        bit seen_done, prev_we;
        logic [7:0] ea, ed, la, ld;
        @(negedge clk);
        start_addr = v.sa;
        end_addr   = v.ea;
        mode       = v.md;
        seed       = v.sd;
        step       = v.st;
        grant      = 1'b1;
        start      = 1'b1;
        @(negedge clk);
        // Scramble inputs: the fill must use the latched values.
        start_addr = 8'($urandom);
        end_addr   = 8'($urandom);
        mode       = 2'($urandom);
        seed       = 8'($urandom);
        step       = 8'($urandom);
        k = 0; cyc = 0; nbusy = 0; seen_done = 0; prev_we = 0;
        la = '0; ld = '0;
        while (!seen_done && cyc < 700) begin
            grant = v.tog ? ~cyc[0] : 1'b1;
            if (v.retrig && cyc == 2) start = 1'b0;
            if (v.retrig && cyc == 3) start = 1'b1;
            #1;
            if (cyc == 0) chk($sformatf("v%0d_busy_first", idx), 32'(busy), 1);
            if (busy) begin
                ea = v.sa + 8'(k);
                ed = exp_data(v, k, ea);
                chk($sformatf("v%0d_addr_k%0d", idx, k), 32'(address), 32'(ea));
                chk($sformatf("v%0d_data_k%0d", idx, k), 32'(ram_in), 32'(ed));
                nbusy++;
            end
            if (write_enable) begin
                k++;
                la = address;
                ld = ram_in;
            end
            if (done) begin
                seen_done = 1;
                chk($sformatf("v%0d_done_after_write", idx), 32'(prev_we), 1);
                chk($sformatf("v%0d_we_in_done", idx), 32'(write_enable), 0);
                chk($sformatf("v%0d_busy_in_done", idx), 32'(busy), 0);
            end
            prev_we = write_enable;
            cyc++;
            @(negedge clk);
        end
        chk($sformatf("v%0d_done_seen", idx), 32'(seen_done), 1);
        chk($sformatf("v%0d_write_count", idx), 32'(k), 32'(v.cnt));
        chk($sformatf("v%0d_last_addr", idx), 32'(la), 32'(v.last_a));
        chk($sformatf("v%0d_last_data", idx), 32'(ld), 32'(v.last_d));
        if (!v.tog) chk($sformatf("v%0d_busy_cycles", idx), 32'(nbusy), 32'(v.cnt));
        grant = 1'b1;
        #1;
        chk($sformatf("v%0d_done_one_cycle", idx), 32'(done), 0);
        chk($sformatf("v%0d_idle_busy", idx), 32'(busy), 0);
        chk($sformatf("v%0d_idle_we", idx), 32'(write_enable), 0);
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int k;
        vecs[0] = '{sa: 8'd0,   ea: 8'd255, md: 2'b00, sd: 8'h00, st: 8'h00,
                    tog: 0, retrig: 1, cnt: 256, last_a: 8'hFF, last_d: 8'hFF};
        vecs[1] = '{sa: 8'd5,   ea: 8'd8,   md: 2'b10, sd: 8'hF0, st: 8'h20,
                    tog: 0, retrig: 0, cnt: 4,   last_a: 8'h08, last_d: 8'h50};
        vecs[2] = '{sa: 8'd254, ea: 8'd1,   md: 2'b01, sd: 8'hAA, st: 8'h00,
                    tog: 1, retrig: 0, cnt: 4,   last_a: 8'h01, last_d: 8'hAA};
        vecs[3] = '{sa: 8'd7,   ea: 8'd7,   md: 2'b11, sd: 8'h33, st: 8'h11,
                    tog: 0, retrig: 0, cnt: 1,   last_a: 8'h07, last_d: 8'h07};
        vecs[4] = '{sa: 8'd250, ea: 8'd3,   md: 2'b10, sd: 8'h01, st: 8'hFF,
                    tog: 0, retrig: 1, cnt: 10,  last_a: 8'h03, last_d: 8'hF8};

        reset = 1'b1; start = 1'b1; grant = 1'b1; abort = 1'b0;
        start_addr = '0; end_addr = '0; mode = '0; seed = '0; step = '0;
        #1;
        chk_zero("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("held_start_busy", 32'(busy), 0);
            chk("held_start_we", 32'(write_enable), 0);
        end
        start = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Reset in the middle of a fill, start held high across it.
        start_addr = 8'd0; end_addr = 8'd255; mode = 2'b00; grant = 1'b1;
        start = 1'b1;
        @(negedge clk);
        k = 0;
        for (int c = 0; c < 10 && k < 3; c++) begin
            #1;
            if (write_enable) k++;
            if (k < 3) @(negedge clk);
        end
        chk("pre_reset_writes", 32'(k), 3);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_zero("midfill_reset");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("post_reset_busy", 32'(busy), 0);
            chk("post_reset_we", 32'(write_enable), 0);
        end
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        #1;
        chk("fresh_fill_busy", 32'(busy), 1);
        chk("fresh_fill_addr", 32'(address), 0);
        chk("fresh_fill_data", 32'(ram_in), 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);

`ifdef RAM_FILLER_ABORT_EN
        start_addr = 8'd0; end_addr = 8'd255; mode = 2'b00; grant = 1'b1;
        start = 1'b1;
        @(negedge clk);
        k = 0;
        for (int c = 0; c < 20 && k < 10; c++) begin
            #1;
            if (write_enable) k++;
            if (k < 10) @(negedge clk);
        end
        @(negedge clk);
        abort = 1'b1;
        #1;
        chk("abort_we_low", 32'(write_enable), 0);
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk("abort_writes", 32'(k), 10);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        @(negedge clk);
        #1;
        chk("abort_no_done", 32'(done), 0);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        #1;
        chk("abort_restart_busy", 32'(busy), 1);
        chk("abort_restart_addr", 32'(address), 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
